// File: rtl/vedic_mac_acc_if.sv
// ----------------------------------------------------------------------------
// vedic_mac_acc_if
// Bundles the product-input stream, the run-control pulse and the sum-output
// handshake of the vedic_mac_acc back end.
//   start/len           : run control (len sampled together with start)
//   in_valid/in_ready   : product beat handshake, prod carries the beat
//   out_valid/out_ready : sum handshake, sum/ovf carry the result
//   busy                : block is in a run or holding a result
// Modport slave is the accumulator side, master is the producer/consumer side.
// ----------------------------------------------------------------------------
interface vedic_mac_acc_if #(
   parameter int ACC_W = 72,
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      prod;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] sum;
   logic             ovf;
   logic             busy;

   modport slave (
      input  start, len, in_valid, prod, out_ready,
      output in_ready, out_valid, sum, ovf, busy
   );

   modport master (
      output start, len, in_valid, prod, out_ready,
      input  in_ready, out_valid, sum, ovf, busy
   );
endinterface

// File: rtl/vedic_mac_acc.sv
// ----------------------------------------------------------------------------
// vedic_mac_acc
// Sequential multiply-accumulate back end for the 32x32 Vedic multiplier.
// A start pulse in IDLE opens a run of len products; each accepted 64-bit
// product is added (unsigned, zero-extended) into an ACC_W-bit accumulator.
// When the last beat is in, the total is offered on sum with out_valid until
// the consumer takes it. ovf is sticky for the run and records any carry out
// of the accumulator.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (FSM, accumulator, counter, ovf)
//   mac : vedic_mac_acc_if.slave (start/len, in_*, prod, out_*, sum, ovf, busy)
// ----------------------------------------------------------------------------
module vedic_mac_acc #(
   parameter int ACC_W = 72,
   parameter int LEN_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   vedic_mac_acc_if.slave      mac
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
   localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
   localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q,   acc_d;
   logic             ovf_q,   ovf_d;
   logic [LEN_W-1:0] cnt_q,   cnt_d;
   logic [LEN_W-1:0] len_q,   len_d;

   // One extra bit on top of the accumulator captures the carry of this beat.
   logic [ACC_W:0]   add_s;

   // Accumulator plus zero-extended product, widened by one bit for the carry.
   always_comb begin
      add_s = {1'b0, acc_q} + (ACC_W + 1)'(mac.prod);
   end

   // Next-state and datapath update for the IDLE/ACCUM/DONE run controller.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE: begin
            if (mac.start) begin
               acc_d = ACC_ZERO;
               ovf_d = 1'b0;
               cnt_d = CNT_ZERO;
               len_d = mac.len;
               // An empty run goes straight to DONE and reports a zero sum.
               if (mac.len == CNT_ZERO) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            // in_ready is high for the whole state, so in_valid alone accepts.
            if (mac.in_valid) begin
               acc_d = add_s[ACC_W-1:0];
               ovf_d = ovf_q | add_s[ACC_W];
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_d == len_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DONE: begin
            // start is deliberately not looked at here, even on the handshake.
            if (mac.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= ACC_ZERO;
         ovf_q   <= 1'b0;
         cnt_q   <= CNT_ZERO;
         len_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   // Handshake flags decode the registered state only; sum/ovf are the
   // registers themselves, so they hold after the handshake.
   always_comb begin
      mac.in_ready  = (state_q == ST_ACCUM);
      mac.out_valid = (state_q == ST_DONE);
      mac.busy      = (state_q != ST_IDLE);
      mac.sum       = acc_q;
      mac.ovf       = ovf_q;
   end

endmodule

// File: tb/tb_vedic_mac_acc.sv
// ----------------------------------------------------------------------------
// tb_vedic_mac_acc
// Drives two accumulators (ACC_W=72 and ACC_W=64) with identical stimulus.
// A run-level model keeps the exact unbounded total of the current run; the
// expected sum of each instance is that total modulo 2^ACC_W and the expected
// ovf is whether the total reached 2^ACC_W.
// ----------------------------------------------------------------------------
module tb_vedic_mac_acc;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [63:0] prod;
   logic        out_ready;

   int total = 0;
   int bad   = 0;
   int runs_done = 0;
   int dut_hs = 0;
   bit chk_en = 1'b0;

   // run-level reference model
   bit           m_coll  = 1'b0;
   bit           m_res   = 1'b0;
   int           m_left  = 0;
   logic [127:0] m_total = '0;

   vedic_mac_acc_if #(.ACC_W(72), .LEN_W(8)) ifa ();
   vedic_mac_acc_if #(.ACC_W(64), .LEN_W(8)) ifb ();

   assign ifa.start = start;     assign ifb.start = start;
   assign ifa.len = len;         assign ifb.len = len;
   assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
   assign ifa.prod = prod;       assign ifb.prod = prod;
   assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

   vedic_mac_acc #(.ACC_W(72), .LEN_W(8)) dut_a (.clk(clk), .rst(rst), .mac(ifa));
   vedic_mac_acc #(.ACC_W(64), .LEN_W(8)) dut_b (.clk(clk), .rst(rst), .mac(ifb));

   always #5 clk = ~clk;

   // reference model: one update per rising edge from the driven inputs
   always @(posedge clk) begin
      if (rst) begin
         m_coll  <= 1'b0;
         m_res   <= 1'b0;
         m_left  <= 0;
         m_total <= '0;
      end else if (m_res) begin
         if (out_ready) m_res <= 1'b0;
      end else if (m_coll) begin
         if (in_valid) begin
            m_total <= m_total + {64'd0, prod};
            m_left  <= m_left - 1;
            if (m_left == 1) begin
               m_coll <= 1'b0;
               m_res  <= 1'b1;
            end
         end
      end else if (start) begin
         m_total <= '0;
         if (len == 8'd0) begin
            m_res <= 1'b1;
         end else begin
            m_coll <= 1'b1;
            m_left <= int'(len);
         end
      end
   end

   // count result handshakes actually seen on the 72-bit instance
   always @(posedge clk) begin
      if (!rst && ifa.out_valid && out_ready) dut_hs <= dut_hs + 1;
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("a_in_ready",  {127'd0, ifa.in_ready},  {127'd0, m_coll});
            chk("a_out_valid", {127'd0, ifa.out_valid}, {127'd0, m_res});
            chk("a_busy",      {127'd0, ifa.busy},      {127'd0, m_coll | m_res});
            chk("a_sum",       {56'd0, ifa.sum},        {56'd0, m_total[71:0]});
            chk("a_ovf",       {127'd0, ifa.ovf},       {127'd0, |m_total[127:72]});
            chk("b_in_ready",  {127'd0, ifb.in_ready},  {127'd0, m_coll});
            chk("b_out_valid", {127'd0, ifb.out_valid}, {127'd0, m_res});
            chk("b_busy",      {127'd0, ifb.busy},      {127'd0, m_coll | m_res});
            chk("b_sum",       {64'd0, ifb.sum},        {64'd0, m_total[63:0]});
            chk("b_ovf",       {127'd0, ifb.ovf},       {127'd0, |m_total[127:64]});
         end
      end
   endtask

   task automatic pin_zero(input string tag);
      chk({tag, "_sum_a"},  {56'd0, ifa.sum}, 128'd0);
      chk({tag, "_sum_b"},  {64'd0, ifb.sum}, 128'd0);
      chk({tag, "_flags_a"}, {123'd0, ifa.in_ready, ifa.out_valid, ifa.busy, ifa.ovf, 1'b0}, 128'd0);
      chk({tag, "_flags_b"}, {123'd0, ifb.in_ready, ifb.out_valid, ifb.busy, ifb.ovf, 1'b0}, 128'd0);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start(input logic [7:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] p, input int gap, input bit stray);
      int n;
      in_valid = 1'b0;
      cyc(gap);
      in_valid = 1'b1;
      prod     = p;
      if (stray) begin
         start = 1'b1;
         len   = 8'd3;
      end
      n = 0;
      while (ifa.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL beat_timeout: in_ready=%b after 50 cycles, expected 1", ifa.in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic get_result(input int delay, input bit stray, input bit pin,
                             input logic [71:0] ea, input logic eo_a,
                             input logic [63:0] eb, input logic eo_b);
      int n;
      out_ready = 1'b0;
      n = 0;
      while (ifa.out_valid !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         bad++;
         $display("FAIL result_timeout: out_valid=%b after 50 cycles, expected 1", ifa.out_valid);
      end
      if (pin) begin
         chk("pin_latency", 128'(n), 128'd0);
         chk("pin_sum_a", {56'd0, ifa.sum}, {56'd0, ea});
         chk("pin_ovf_a", {127'd0, ifa.ovf}, {127'd0, eo_a});
         chk("pin_sum_b", {64'd0, ifb.sum}, {64'd0, eb});
         chk("pin_ovf_b", {127'd0, ifb.ovf}, {127'd0, eo_b});
      end
      cyc(delay);
      out_ready = 1'b1;
      if (stray) begin
         start = 1'b1;
         len   = 8'd2;
      end
      @(negedge clk);
      out_ready = 1'b0;
      start     = 1'b0;
      runs_done++;
      if (pin) begin
         chk("pin_after_hs_valid", {127'd0, ifa.out_valid}, 128'd0);
         chk("pin_after_hs_sum",   {56'd0, ifa.sum}, {56'd0, ea});
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
      prod = 64'd0; out_ready = 1'b0;
      fork
         compare_loop();
      join_none
      @(posedge clk);
      chk_en = 1'b1;
      cyc(2);
      pin_zero("reset");
      rst = 1'b0;
      cyc(1);

      // basic run: 15 + 42 + 0x1FFFFFFFE = 0x200000037
      do_start(8'd3);
      send_beat(64'd15, 0, 1'b0);
      send_beat(64'd42, 0, 1'b0);
      send_beat(64'h0000_0001_FFFF_FFFE, 0, 1'b0);
      get_result(0, 1'b0, 1'b1, 72'h00_0000_0002_0000_0037, 1'b0,
                 64'h0000_0002_0000_0037, 1'b0);
      cyc(1);

      // stalls of 3 cycles and 5 cycles of backpressure
      do_start(8'd2);
      send_beat(64'd100, 3, 1'b0);
      send_beat(64'd200, 3, 1'b0);
      get_result(5, 1'b0, 1'b1, 72'd300, 1'b0, 64'd300, 1'b0);
      cyc(1);

      // zero length
      do_start(8'd0);
      get_result(0, 1'b0, 1'b1, 72'd0, 1'b0, 64'd0, 1'b0);
      cyc(1);

      // overflow only in the 64-bit instance
      do_start(8'd2);
      send_beat(64'hFFFF_FFFE_0000_0001, 0, 1'b0);
      send_beat(64'hFFFF_FFFE_0000_0001, 0, 1'b0);
      get_result(0, 1'b0, 1'b1, 72'h01_FFFF_FFFC_0000_0002, 1'b0,
                 64'hFFFF_FFFC_0000_0002, 1'b1);
      do_start(8'd1);
      send_beat(64'd1, 0, 1'b0);
      get_result(0, 1'b0, 1'b1, 72'd1, 1'b0, 64'd1, 1'b0);

      // reset in the middle of a run
      do_start(8'd4);
      send_beat(64'd11, 0, 1'b0);
      send_beat(64'd22, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      pin_zero("midrst");
      rst = 1'b0;
      do_start(8'd1);
      send_beat(64'd7, 0, 1'b0);
      get_result(0, 1'b0, 1'b1, 72'd7, 1'b0, 64'd7, 1'b0);

      // stray start pulses during ACCUM and the DONE handshake
      do_start(8'd2);
      send_beat(64'd5, 0, 1'b1);
      send_beat(64'd6, 0, 1'b1);
      get_result(1, 1'b1, 1'b1, 72'd11, 1'b0, 64'd11, 1'b0);
      cyc(3);
      chk("stray_busy", {127'd0, ifa.busy}, 128'd0);

      // randomized runs
      for (int r = 0; r < 40; r++) begin
         int l;
         int rst_at;
         bit aborted;
         l = $urandom_range(0, 12);
         rst_at = (($urandom % 10) == 0 && l > 1) ? l / 2 : -1;
         aborted = 1'b0;
         do_start(8'(l));
         for (int b = 0; b < l; b++) begin
            logic [63:0] p;
            if (b == rst_at) begin
               rst = 1'b1;
               @(negedge clk);
               rst = 1'b0;
               aborted = 1'b1;
               break;
            end
            if (($urandom % 2) == 0) p = {$urandom | 32'hF000_0000, $urandom};
            else                     p = 64'($urandom_range(0, 1000));
            send_beat(p, $urandom_range(0, 2), (($urandom % 8) == 0));
         end
         if (!aborted) begin
            get_result($urandom_range(0, 3), (($urandom % 4) == 0), 1'b0,
                       72'd0, 1'b0, 64'd0, 1'b0);
         end
         cyc($urandom_range(0, 2));
      end

      cyc(2);
      chk("handshake_count", 128'(dut_hs), 128'(runs_done));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
